// File: rtl/ocm_rr_arbiter.sv
// Two-requester round-robin front end for a 1024x32 SDP memory: writes on port A, reads on port B, arbitrated independently.
// Grant is combinational, memory controls are registered, read data returns 2 cycles after accept; losers hold req and are counted as stalls.
module ocm_rr_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [CNT_W-1:0]  m0_stall_cnt,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [CNT_W-1:0]  m1_stall_cnt,
  output logic [ADDR_W-1:0] mem_addr_A,
  output logic [DATA_W-1:0] mem_din_A,
  output logic              mem_wen_A,
  output logic [ADDR_W-1:0] mem_addr_B,
  output logic              mem_ren_B,
  input  logic [DATA_W-1:0] mem_dout_B
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_cmd_t;

  logic    wr_ptr, rd_ptr;
  logic    cw0, cw1, cr0, cr1;
  logic    w_any, r_any, w_sel1, r_sel1;
  wr_cmd_t w_win;
  logic    rd_tag, rsp_vld, rsp_tag;
  logic    stall0, stall1;

  // Pointer value 1 means m1 holds priority when both requesters compete.
  always_comb begin
    cw0    = m0_req & m0_we;
    cw1    = m1_req & m1_we;
    cr0    = m0_req & ~m0_we;
    cr1    = m1_req & ~m1_we;
    w_any  = cw0 | cw1;
    r_any  = cr0 | cr1;
    w_sel1 = cw1 & (~cw0 | wr_ptr);
    r_sel1 = cr1 & (~cr0 | rd_ptr);
    w_win  = w_sel1 ? wr_cmd_t'{addr: m1_addr, data: m1_wdata}
                    : wr_cmd_t'{addr: m0_addr, data: m0_wdata};
  end

  assign m0_gnt = rst_n & ((cw0 & ~w_sel1) | (cr0 & ~r_sel1));
  assign m1_gnt = rst_n & ((cw1 & w_sel1) | (cr1 & r_sel1));
  assign stall0 = m0_req & ~m0_gnt;
  assign stall1 = m1_req & ~m1_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      mem_wen_A  <= 1'b0;
      mem_addr_A <= '0;
      mem_din_A  <= '0;
      mem_ren_B  <= 1'b0;
      mem_addr_B <= '0;
      rd_tag     <= 1'b0;
      rsp_vld    <= 1'b0;
      rsp_tag    <= 1'b0;
    end else begin
      mem_wen_A <= w_any;
      mem_ren_B <= r_any;
      if (w_any) begin
        wr_ptr     <= ~w_sel1;
        mem_addr_A <= w_win.addr;
        mem_din_A  <= w_win.data;
      end
      if (r_any) begin
        rd_ptr     <= ~r_sel1;
        mem_addr_B <= r_sel1 ? m1_addr : m0_addr;
        rd_tag     <= r_sel1;
      end
      // Tag follows the memory's one-cycle read latency so data returns to its owner.
      rsp_vld <= mem_ren_B;
      rsp_tag <= rd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (stall0 && (m0_stall_cnt != {CNT_W{1'b1}}))
        m0_stall_cnt <= m0_stall_cnt + CNT_W'(1);
      if (stall1 && (m1_stall_cnt != {CNT_W{1'b1}}))
        m1_stall_cnt <= m1_stall_cnt + CNT_W'(1);
    end
  end

  assign m0_rvalid = rsp_vld & ~rsp_tag;
  assign m1_rvalid = rsp_vld & rsp_tag;
  assign m0_rdata  = m0_rvalid ? mem_dout_B : '0;
  assign m1_rdata  = m1_rvalid ? mem_dout_B : '0;

endmodule

// File: tb/tb_ocm_rr_arbiter.sv
// Directed bench for ocm_rr_arbiter with a read-first SDP memory model; stall counters built 4 bits wide.
module tb_ocm_rr_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [CW-1:0] m0_stall_cnt, m1_stall_cnt;
  logic [AW-1:0] mem_addr_A, mem_addr_B;
  logic [DW-1:0] mem_din_A, mem_dout_B;
  logic          mem_wen_A, mem_ren_B;

  logic [DW-1:0] mem_arr [0:1023];
  logic [DW-1:0] gold    [0:1023];
  int checks;
  int errors;

  ocm_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_stall_cnt(m0_stall_cnt),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_stall_cnt(m1_stall_cnt),
    .mem_addr_A(mem_addr_A), .mem_din_A(mem_din_A), .mem_wen_A(mem_wen_A),
    .mem_addr_B(mem_addr_B), .mem_ren_B(mem_ren_B), .mem_dout_B(mem_dout_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first memory: the read samples the array before this edge's write lands.
  always @(posedge clk) begin
    if (mem_wen_A) mem_arr[mem_addr_A] <= mem_din_A;
    if (mem_ren_B) mem_dout_B <= mem_arr[mem_addr_B];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    tick();
    tick();
    checks++; if ({mem_wen_A, mem_ren_B, m0_rvalid, m1_rvalid} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_wen_A, mem_ren_B, m0_rvalid, m1_rvalid}); end
    checks++; if ({mem_addr_A, mem_addr_B} !== '0) begin errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", mem_addr_A, mem_addr_B); end
    checks++; if ({m0_stall_cnt, m1_stall_cnt} !== '0) begin errors++; $display("FAIL reset_stall: got %0d/%0d expected 0/0", m0_stall_cnt, m1_stall_cnt); end
    m0_req = 1;
    #1;
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt_forced: got %b expected 0", m0_gnt); end
    idle();
    rst_n = 1;
    tick();
    // Read in flight when reset hits mid-stream.
    m0_req = 1; m0_addr = 10'd1; m1_req = 1; m1_addr = 10'd2;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL reset_pre_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    tick();
    idle();
    #1;
    checks++; if (mem_ren_B !== 1'b1) begin errors++; $display("FAIL reset_pre_ren: got %b expected 1", mem_ren_B); end
    checks++; if (m1_stall_cnt !== 4'd1) begin errors++; $display("FAIL reset_pre_stall: got %0d expected 1", m1_stall_cnt); end
    #1 rst_n = 0;
    #1;
    checks++; if ({mem_ren_B, m0_rvalid, m1_rvalid} !== 3'b0) begin errors++; $display("FAIL reset_async_drop: got %b expected 000", {mem_ren_B, m0_rvalid, m1_rvalid}); end
    checks++; if (m1_stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_async_stall: got %0d expected 0", m1_stall_cnt); end
    tick();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_no_stale_rvalid c%0d: got %b expected 00", c, {m0_rvalid, m1_rvalid}); end
    end
  endtask

  task automatic test_solo_write_read();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL solo_wr_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    tick();
    idle();
    gold[5] = 32'hDEADBEEF;
    #1;
    checks++; if ({mem_wen_A, mem_addr_A, mem_din_A} !== {1'b1, 10'h005, 32'hDEADBEEF}) begin errors++; $display("FAIL solo_wr_issue: got %b %h %h expected 1 005 deadbeef", mem_wen_A, mem_addr_A, mem_din_A); end
    tick();
    checks++; if ({mem_wen_A, mem_addr_A} !== {1'b0, 10'h005}) begin errors++; $display("FAIL solo_wr_idle_hold: got %b %h expected 0 005", mem_wen_A, mem_addr_A); end
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL solo_rd_gnt: got %b expected 1", m0_gnt); end
    tick();
    idle();
    #1;
    checks++; if ({mem_ren_B, mem_addr_B, m0_rvalid} !== {1'b1, 10'h005, 1'b0}) begin errors++; $display("FAIL solo_rd_issue: got %b %h %b expected 1 005 0", mem_ren_B, mem_addr_B, m0_rvalid); end
    tick();
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL solo_rd_data: got %b %h expected 1 deadbeef", m0_rvalid, m0_rdata); end
    checks++; if ({m1_rvalid, m1_rdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL solo_rd_other: got %b %h expected 0 0", m1_rvalid, m1_rdata); end
    tick();
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL solo_rd_one_cycle: got %b %h expected 0 0", m0_rvalid, m0_rdata); end
  endtask

  task automatic test_write_contention();
    logic [DW-1:0] exp_din;
    exp_din = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m0_we = 1; m0_addr = AW'(16 + i); m0_wdata = 32'h1000_0000 + DW'(i);
      m1_req = 1; m1_we = 1; m1_addr = AW'(32 + i); m1_wdata = 32'h2000_0000 + DW'(i);
      #1;
      checks++; if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL wr_cont_gnt i%0d: got %b", i, {m0_gnt, m1_gnt}); end
      if (i > 0) begin
        checks++; if (mem_din_A !== exp_din) begin errors++; $display("FAIL wr_cont_din i%0d: got %h expected %h", i, mem_din_A, exp_din); end
      end
      exp_din = (i % 2 == 0) ? 32'h1000_0000 + DW'(i) : 32'h2000_0000 + DW'(i);
      tick();
    end
    idle();
    #1;
    checks++; if ({mem_wen_A, mem_din_A, mem_addr_A} !== {1'b1, exp_din, 10'd35}) begin errors++; $display("FAIL wr_cont_last: got %b %h %h expected 1 %h 023", mem_wen_A, mem_din_A, mem_addr_A, exp_din); end
    checks++; if ({m0_stall_cnt, m1_stall_cnt} !== {4'd2, 4'd2}) begin errors++; $display("FAIL wr_cont_stall: got %0d/%0d expected 2/2", m0_stall_cnt, m1_stall_cnt); end
  endtask

  task automatic test_concurrent_ports();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 10'h3FF; m1_wdata = 32'hA5A5A5A5;
    tick();
    idle();
    tick();
    m0_req = 1; m0_we = 1; m0_addr = 10'h3FF; m0_wdata = 32'h11111111;
    m1_req = 1; m1_we = 0; m1_addr = 10'h3FF;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b11) begin errors++; $display("FAIL conc_gnt: got %b expected 11", {m0_gnt, m1_gnt}); end
    tick();
    idle();
    gold[10'h3FF] = 32'h11111111;
    #1;
    checks++; if ({mem_wen_A, mem_ren_B} !== 2'b11) begin errors++; $display("FAIL conc_issue: got %b expected 11", {mem_wen_A, mem_ren_B}); end
    tick();
    checks++; if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 32'hA5A5A5A5, 1'b0}) begin errors++; $display("FAIL conc_read_first: got %b %h %b expected 1 a5a5a5a5 0", m1_rvalid, m1_rdata, m0_rvalid); end
    m1_req = 1; m1_we = 0; m1_addr = 10'h3FF;
    #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL conc_reread_gnt: got %b expected 1", m1_gnt); end
    tick();
    idle();
    tick();
    checks++; if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h11111111}) begin errors++; $display("FAIL conc_reread_data: got %b %h expected 1 11111111", m1_rvalid, m1_rdata); end
  endtask

  task automatic test_read_contention();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    m1_req = 1; m1_we = 0; m1_addr = 10'h3FF;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rd_cont_gnt0: got %b expected 10", {m0_gnt, m1_gnt}); end
    tick();
    m0_req = 0;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL rd_cont_gnt1: got %b expected 01", {m0_gnt, m1_gnt}); end
    tick();
    idle();
    #1;
    checks++; if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin errors++; $display("FAIL rd_cont_ret0: got %b %h %b", m0_rvalid, m0_rdata, m1_rvalid); end
    tick();
    checks++; if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 32'h11111111, 1'b0}) begin errors++; $display("FAIL rd_cont_ret1: got %b %h %b", m1_rvalid, m1_rdata, m0_rvalid); end
    checks++; if (m1_stall_cnt !== 4'd1) begin errors++; $display("FAIL rd_cont_stall: got %0d expected 1", m1_stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      d = $urandom;
      m0_req = 1; m0_we = 1; m0_addr = AW'(i); m0_wdata = d;
      gold[i] = d;
      tick();
    end
    idle();
    tick();
    for (int c = 0; c < 1026; c++) begin
      if (c < 1024) begin
        m1_req = 1; m1_we = 0; m1_addr = AW'(c);
      end else begin
        idle();
      end
      #1;
      if (c < 1024) begin
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL stream_gnt c%0d: got %b expected 1", c, m1_gnt); end
      end
      checks++; if ({m1_rvalid, m0_rvalid} !== {(c >= 2), 1'b0}) begin errors++; $display("FAIL stream_rvalid c%0d: got %b expected %b0", c, {m1_rvalid, m0_rvalid}, (c >= 2)); end
      if (c >= 2) begin
        checks++; if (m1_rdata !== gold[c-2]) begin errors++; $display("FAIL stream_data addr%0d: got %h expected %h", c - 2, m1_rdata, gold[c-2]); end
      end
      tick();
    end
    checks++; if ({m1_rvalid, m1_stall_cnt, m0_stall_cnt} !== '0) begin errors++; $display("FAIL stream_end: got rvalid %b stalls %0d/%0d expected 0 0/0", m1_rvalid, m1_stall_cnt, m0_stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      m0_req = 1; m0_we = 1; m0_addr = AW'(100 + i); m0_wdata = DW'(i);
      m1_req = 1; m1_we = 1; m1_addr = AW'(200 + i); m1_wdata = DW'(i);
      if (i == 20) begin
        checks++; if ({m0_stall_cnt, m1_stall_cnt} !== {4'd10, 4'd10}) begin errors++; $display("FAIL sat_mid: got %0d/%0d expected 10/10", m0_stall_cnt, m1_stall_cnt); end
      end
      tick();
    end
    idle();
    #1;
    checks++; if ({m0_stall_cnt, m1_stall_cnt} !== {4'd15, 4'd15}) begin errors++; $display("FAIL sat_cap: got %0d/%0d expected 15/15", m0_stall_cnt, m1_stall_cnt); end
    tick();
    tick();
    checks++; if (m1_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", m1_stall_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 0;
    idle();
    test_reset();
    test_solo_write_read();
    test_write_contention();
    test_concurrent_ports();
    test_read_contention();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ocm_rr_arbiter.md
Name: ocm_rr_arbiter

Overview:
- Shares one simple-dual-port on-chip memory (1024x32, write port A, registered read port B) between two requesters, m0 and m1.
- Write traffic is arbitrated round-robin onto port A. Read traffic is arbitrated round-robin onto port B, independently of writes, so one write and one read can issue in the same cycle.
- Sits between the requesters and the memory instance. All memory-side controls are registered.

Parameters:
- ADDR_W, 10, address width (memory depth = 2**ADDR_W).
- DATA_W, 32, data width.
- CNT_W, 16, width of the stall counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mK_req  in  1  request, K in {0,1}; held until granted.
- mK_we  in  1  1 = write, 0 = read; stable while mK_req=1.
- mK_addr  in  ADDR_W  access address.
- mK_wdata  in  DATA_W  write data.
- mK_gnt  out  1  request accepted this cycle.
- mK_rvalid  out  1  read data valid.
- mK_rdata  out  DATA_W  read data; 0 when mK_rvalid=0.
- mK_stall_cnt  out  CNT_W  saturating count of cycles with mK_req=1 and mK_gnt=0.
- mem_addr_A  out  ADDR_W  write address.
- mem_din_A  out  DATA_W  write data.
- mem_wen_A  out  1  write enable.
- mem_addr_B  out  ADDR_W  read address.
- mem_ren_B  out  1  read enable.
- mem_dout_B  in  DATA_W  memory read data; valid 1 cycle after mem_ren_B is sampled.

Behaviour:
- Reset (rst_n=0, async):
  - mem_* outputs, mK_rvalid, mK_stall_cnt = 0.
  - Both priority pointers = m0.
  - mK_gnt forced 0 while rst_n=0.
- Handshake: a transaction is accepted in the cycle where mK_req & mK_gnt = 1. Grant is combinational from req/we and the pointer; no wait state when uncontended.
- Write arbiter (candidates with req & we):
  - One candidate: it is granted.
  - Both candidates: the one selected by wr_ptr is granted.
  - After any write grant, wr_ptr points to the other requester.
- Read arbiter (candidates with req & !we): same rules, using rd_ptr.
- At most one grant per requester per cycle; a requester is a candidate in only one arbiter.
- Issue stage: on the edge closing an accept cycle t:
  - Write: mem_wen_A=1, mem_addr_A and mem_din_A loaded from the winner.
  - Read: mem_ren_B=1, mem_addr_B loaded, and a 1-bit read tag (winner id) is stored.
  - No accept: the corresponding enable returns to 0; address and data hold their last values.
- Read latency: read accepted in cycle t → mem_ren_B=1 in t+1 → mK_rvalid=1 for exactly one cycle in t+2, with mK_rdata=mem_dout_B. The other requester's rvalid stays 0.
- Back-to-back reads are fully pipelined: one per cycle, returned in acceptance order.
- Read/write same address:
  - Accepted in the same cycle: the read returns pre-write data (read-first).
  - Read accepted one or more cycles after the write: the read returns new data.
- Stall counters: increment when mK_req=1 and mK_gnt=0. They saturate at 2**CNT_W-1 and clear only on reset.
- Reset mid-operation: in-flight reads are discarded. No rvalid is produced after rst_n deasserts for reads accepted before the reset.
- Address wrap: none inside the block; requesters own address generation.

Test Plan:
- Reset: drive rst_n=0 mid-stream with m0 read in flight → mem_ren_B, m0_rvalid, and stall counters drop to 0 immediately; no rvalid after release.
- Solo write/read: m0 writes 0xDEADBEEF to addr 0x005 (gnt same cycle, mem_wen_A=1 next cycle); m0 then reads 0x005 → m0_rvalid 2 cycles after accept, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Write contention: m0 and m1 both write continuously for 4 cycles → grants alternate m0,m1,m0,m1; m0_stall_cnt=2, m1_stall_cnt=2.
- Concurrent ports: m0 writes 0x11111111 to addr 0x3FF while m1 reads 0x3FF (prior contents 0xA5A5A5A5) in the same cycle → both granted; m1_rdata=0xA5A5A5A5. A repeat read by m1 returns 0x11111111.
- Streaming reads: m1 reads addrs 0..1023 back-to-back, pre-filled with random data → one rvalid per cycle, all data match a golden memory model, zero stalls.
- Saturation: with CNT_W=4, hold m1 write request blocked by alternating contention for 40 cycles → m1_stall_cnt stops at 15.
